// File: rtl/gfsk_demodulation.sv
// gfsk_demodulation: FM discriminator and per-symbol bit slicer for BTLE baseband I/Q.
// Optional macro GFSK_DEMODULATION_INTEGRATE_EN sums the discriminator over each symbol before slicing.
module gfsk_demodulation #(
    parameter int IQ_BIT_WIDTH      = 8,
    parameter int SAMPLE_PER_SYMBOL = 8,
    parameter int DISC_BIT_WIDTH    = 2*IQ_BIT_WIDTH+1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic signed [IQ_BIT_WIDTH-1:0]   i_in,
    input  logic signed [IQ_BIT_WIDTH-1:0]   q_in,
    input  logic                             iq_valid,
    input  logic                             iq_valid_last,
    input  logic        [3:0]                phase_sel,
    output logic signed [DISC_BIT_WIDTH-1:0] disc,
    output logic                             disc_valid,
    output logic                             bit_out,
    output logic                             bit_valid,
    output logic                             bit_valid_last
);
    localparam int CW = $clog2(SAMPLE_PER_SYMBOL);
    typedef enum logic {IDLE, RUN} state_t;
    state_t                            state_q, state_d;
    logic signed [IQ_BIT_WIDTH-1:0]    i_prev_q, i_prev_d, q_prev_q, q_prev_d;
    logic        [3:0]                 phase_q, phase_d;
    logic        [CW-1:0]              cnt_q, cnt_d;
    logic signed [DISC_BIT_WIDTH-1:0]  disc_q, disc_d;
    logic                              disc_valid_q, disc_valid_d, disc_last_q, disc_last_d;
    logic                              bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
    logic                              bit_valid_last_q, bit_valid_last_d;
    logic                              hit;
    // Decision point: the stage-1 sample sits at the packet's latched phase
    assign hit = disc_valid_q && (4'(cnt_q) == phase_q);
`ifdef GFSK_DEMODULATION_INTEGRATE_EN
    localparam int AW = DISC_BIT_WIDTH + CW;
    logic signed [AW-1:0] acc_q, acc_d, dec;
    // Running symbol sum; restarts after each decision and at end of packet
    always_comb begin
        dec   = acc_q + AW'(disc_q);
        acc_d = !disc_valid_q ? acc_q : (hit || disc_last_q) ? '0 : dec;
    end
    // Accumulator register
    always_ff @(posedge clk) acc_q <= rst ? '0 : acc_d;
`else
    logic signed [DISC_BIT_WIDTH-1:0] dec;
    // Decision uses the instantaneous discriminator
    always_comb dec = disc_q;
`endif
    // FSM, stage-1 discriminator, symbol counter and stage-2 slicer
    always_comb begin
        state_d          = state_q;
        phase_d          = phase_q;
        i_prev_d         = i_prev_q;
        q_prev_d         = q_prev_q;
        disc_d           = disc_q;
        if (iq_valid) begin
            state_d  = iq_valid_last ? IDLE : RUN;
            phase_d  = (state_q == IDLE) ? phase_sel : phase_q;
            disc_d   = DISC_BIT_WIDTH'(i_prev_q) * DISC_BIT_WIDTH'(q_in)
                     - DISC_BIT_WIDTH'(q_prev_q) * DISC_BIT_WIDTH'(i_in);
            i_prev_d = iq_valid_last ? '0 : i_in;
            q_prev_d = iq_valid_last ? '0 : q_in;
        end
        disc_valid_d     = iq_valid;
        disc_last_d      = iq_valid && iq_valid_last;
        cnt_d            = !disc_valid_q ? cnt_q
                         : (disc_last_q || cnt_q == CW'(SAMPLE_PER_SYMBOL-1)) ? '0 : cnt_q + 1'b1;
        bit_valid_d      = hit;
        bit_out_d        = hit ? (dec > 0) : bit_out_q;
        bit_valid_last_d = disc_last_q;
    end
    // Pipeline and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            phase_q          <= '0;
            i_prev_q         <= '0;
            q_prev_q         <= '0;
            cnt_q            <= '0;
            disc_q           <= '0;
            disc_valid_q     <= 1'b0;
            disc_last_q      <= 1'b0;
            bit_out_q        <= 1'b0;
            bit_valid_q      <= 1'b0;
            bit_valid_last_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            phase_q          <= phase_d;
            i_prev_q         <= i_prev_d;
            q_prev_q         <= q_prev_d;
            cnt_q            <= cnt_d;
            disc_q           <= disc_d;
            disc_valid_q     <= disc_valid_d;
            disc_last_q      <= disc_last_d;
            bit_out_q        <= bit_out_d;
            bit_valid_q      <= bit_valid_d;
            bit_valid_last_q <= bit_valid_last_d;
        end
    end
    assign disc           = disc_q;
    assign disc_valid     = disc_valid_q;
    assign bit_out        = bit_out_q;
    assign bit_valid      = bit_valid_q;
    assign bit_valid_last = bit_valid_last_q;
endmodule

// File: tb/tb_gfsk_demodulation.sv
// tb_gfsk_demodulation: randomized and directed packets scored against a per-packet symbol model.
module tb_gfsk_demodulation;
    localparam int SPS = 8;
`ifdef GFSK_DEMODULATION_INTEGRATE_EN
    localparam bit INTEG = 1'b1;
`else
    localparam bit INTEG = 1'b0;
`endif
    typedef struct {int cyc; int val;} ev_t;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [7:0]  i_in = '0, q_in = '0;
    logic               iq_valid = 1'b0, iq_valid_last = 1'b0;
    logic        [3:0]  phase_sel = '0;
    logic signed [16:0] disc;
    logic               disc_valid, bit_out, bit_valid, bit_valid_last;
    int                 cyc = 0, n_vec = 0, n_err = 0, hold = 0;
    bit                 chk_en = 1'b0;
    ev_t                qd[$], qb[$];
    int                 ql[$];
    int                 ri[4] = '{64, 0, -64, 0};
    int                 rq[4] = '{0, 64, 0, -64};

    gfsk_demodulation dut (
        .clk(clk), .rst(rst), .i_in(i_in), .q_in(q_in), .iq_valid(iq_valid),
        .iq_valid_last(iq_valid_last), .phase_sel(phase_sel), .disc(disc),
        .disc_valid(disc_valid), .bit_out(bit_out), .bit_valid(bit_valid),
        .bit_valid_last(bit_valid_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        bit ed, eb, el;
        ed = qd.size() > 0 && qd[0].cyc == cyc;
        eb = qb.size() > 0 && qb[0].cyc == cyc;
        el = ql.size() > 0 && ql[0] == cyc;
        chk("disc_valid", disc_valid, ed);
        if (ed) begin
            chk("disc", disc, qd[0].val);
            void'(qd.pop_front());
        end
        if (eb) begin
            hold = qb[0].val;
            void'(qb.pop_front());
        end
        chk("bit_valid", bit_valid, eb);
        chk("bit_out", bit_out, hold);
        chk("bit_valid_last", bit_valid_last, el);
        if (el) void'(ql.pop_front());
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            iq_valid = 1'($urandom_range(0, 1));
            iq_valid_last = 1'($urandom_range(0, 1));
            i_in = 8'($urandom_range(0, 255));
            q_in = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            qd.delete(); qb.delete(); ql.delete();
            hold = 0;
            chk_en = 1'b1;
            chk("rst_disc", disc, 0);
        end
        rst = 1'b0;
        iq_valid = 1'b0;
        iq_valid_last = 1'b0;
    endtask

    // mode 0: +90 deg/sample, 1: -90 deg, 2: random I/Q, 3: +90 for 8 samples then frozen
    task automatic send_pkt(input int n, input int mode, input int ph, input int gapmax, input int abort_at);
        int ip = 0, qp = 0, ii, qq, d, acc = 0;
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                do_reset(2);
                return;
            end
            repeat ($urandom_range(0, gapmax)) begin
                iq_valid = 1'b0;
                iq_valid_last = 1'($urandom_range(0, 1));
                phase_sel = 4'($urandom_range(0, 15));
                @(posedge clk); #1;
            end
            case (mode)
                0: begin ii = ri[k%4]; qq = rq[k%4]; end
                1: begin ii = ri[k%4]; qq = -rq[k%4]; end
                2: begin ii = int'($urandom_range(0, 255)) - 128; qq = int'($urandom_range(0, 255)) - 128; end
                default: begin ii = ri[(k < 8 ? k : 7)%4]; qq = rq[(k < 8 ? k : 7)%4]; end
            endcase
            iq_valid = 1'b1;
            iq_valid_last = (k == n-1);
            i_in = 8'(ii);
            q_in = 8'(qq);
            phase_sel = (k == 0) ? 4'(ph) : 4'($urandom_range(0, 15));
            d = ip*qq - qp*ii;
            qd.push_back('{cyc+1, d});
            if (k % SPS == ph) begin
                qb.push_back('{cyc+2, int'(((INTEG ? acc + d : d) > 0))});
                acc = 0;
            end else acc += d;
            if (k == n-1) ql.push_back(cyc+2);
            ip = ii;
            qp = qq;
            @(posedge clk); #1;
        end
        iq_valid = 1'b0;
        iq_valid_last = 1'b0;
    endtask

    initial begin
        do_reset(4);
        send_pkt(32, 0, 3, 0, -1);
        send_pkt(32, 1, 3, 0, -1);
        send_pkt(18, 0, 3, 0, -1);
        repeat (3) @(posedge clk);
        #1;
        send_pkt(16, 0, 3, 0, 10);
        send_pkt(16, 0, 3, 0, -1);
        send_pkt(16, 3, 7, 0, -1);
        send_pkt(16, 0, 7, 0, -1);
        send_pkt(1, 2, 0, 0, -1);
        send_pkt(20, 0, 9, 1, -1);
        for (int p = 0; p < 40; p++)
            send_pkt($urandom_range(1, 40), $urandom_range(0, 3), $urandom_range(0, 9),
                     $urandom_range(0, 2), ($urandom_range(0, 9) == 0) ? $urandom_range(1, 20) : -1);
        repeat (4) @(posedge clk);
        #1;
        chk("drain_disc", qd.size(), 0);
        chk("drain_bit", qb.size(), 0);
        chk("drain_last", ql.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
